// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MUL/MULHU/DIVU/REMU sequencer that stalls the execute stage; divider built only with MULDIV_DIV_EN.
module muldiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         stall,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [N-1:0] b_q, div_res, imm_res, res_busy;
  logic [2*N-1:0] prod, prod_nx;
  logic [N:0] sum;
  logic launch, last, imm_go, imm_err;
`ifdef MULDIV_DIV_EN
  logic [N-1:0] rem, rem_nx, quo, quo_nx;
  logic [N:0] rs, diff;
  always_comb begin
    rs = {rem, quo[N-1]};
    diff = rs - {1'b0, b_q};
    rem_nx = diff[N] ? rs[N-1:0] : diff[N-1:0];
    quo_nx = {quo[N-2:0], ~diff[N]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      quo <= '0;
    end else if (launch) begin
      rem <= '0;
      quo <= a;
    end else if (state == BUSY) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end
  assign div_res = op_q[0] ? rem_nx : quo_nx;
  assign imm_go = op[1] & (b == '0);
  assign imm_res = op[0] ? a : '1;
  assign imm_err = 1'b0;
`else
  // DIVU/REMU are rejected at issue and complete immediately with err
  assign div_res = '0;
  assign imm_go = op[1];
  assign imm_res = '0;
  assign imm_err = 1'b1;
`endif
  always_comb begin
    launch = (state == IDLE) & start & ~flush;
    last = cnt == CW'(N - 1);
    sum = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, b_q} : '0);
    prod_nx = {sum, prod[N-1:1]};
    res_busy = op_q[1] ? div_res : (op_q[0] ? prod_nx[2*N-1:N] : prod_nx[N-1:0]);
    state_nx = state;
    if (state == IDLE) state_nx = launch ? (imm_go ? DONE : BUSY) : IDLE;
    else if (state == BUSY) state_nx = flush ? IDLE : (last ? DONE : BUSY);
    else state_nx = IDLE;
    stall = ~rst & (launch | (state == BUSY));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      result <= '0;
      cnt <= '0;
      op_q <= '0;
      b_q <= '0;
      prod <= '0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      done <= state_nx == DONE;
      err <= launch & imm_go & imm_err;
      cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
      if (launch) begin
        op_q <= op;
        b_q <= b;
        prod <= {{N{1'b0}}, a};
        if (imm_go) result <= imm_res;
      end
      if (state == BUSY) begin
        prod <= prod_nx;
        if (last & ~flush) result <= res_busy;
      end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq; divide cases compiled in with MULDIV_DIV_EN.
module tb_muldiv_seq;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst, start, flush;
  logic [1:0] op;
  logic [N-1:0] a, b;
  logic stall, busy, done, err;
  logic [N-1:0] result;
  int checks = 0;
  int errors = 0;

  muldiv_seq #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue at a negedge, hold start until done, then confirm the DONE-cycle start was ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        input int lat, input logic [N-1:0] exp, input logic eerr);
    int cyc = 0;
    int scnt;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 chk({tag, " stall@T"}, 64'(stall), 64'd1);
    scnt = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!done && stall) scnt++;
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " stall cycles"}, 64'(scnt), 64'(lat));
    chk({tag, " result"}, 64'(result), 64'(exp));
    chk({tag, " err"}, 64'(err), 64'(eerr));
    chk({tag, " stall@done"}, 64'(stall), 64'd0);
    chk({tag, " busy@done"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    chk({tag, " done pulse"}, 64'(done), 64'd0);
    start = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = 2'b00; a = 32'd9; b = 32'd9;
    repeat (2) @(negedge clk);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    start = 1'b0;
    rst = 1'b0;

    run_op("mul 6x7", 2'b00, 32'd6, 32'd7, N + 1, 32'd42, 1'b0);
    run_op("mulhu ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, N + 1, 32'hFFFF_FFFE, 1'b0);
    run_op("mul ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, N + 1, 32'h0000_0001, 1'b0);
    run_op("mulhu mix", 2'b01, 32'h8000_0000, 32'd6, N + 1, 32'd3, 1'b0);

    // flush at T+10 aborts without done and keeps the old result
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    chk("flush busy T+1", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush stall T+10", 64'(stall), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy T+11", 64'(busy), 64'd0);
    chk("flush stall T+11", 64'(stall), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("flush no done", 64'(seen), 64'd0);
    chk("flush result kept", 64'(result), 64'd3);

    // start and flush together in IDLE launch nothing
    start = 1'b1; flush = 1'b1;
    #1 chk("start+flush stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start+flush busy", 64'(busy), 64'd0);

    // async reset in the middle of an op
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst stall", 64'(stall), 64'd0);
    chk("arst result", 64'(result), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul 3x5", 2'b00, 32'd3, 32'd5, N + 1, 32'd15, 1'b0);

`ifdef MULDIV_DIV_EN
    run_op("divu 100/7", 2'b10, 32'd100, 32'd7, N + 1, 32'd14, 1'b0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, N + 1, 32'd2, 1'b0);
    run_op("divu max/3", 2'b10, 32'hFFFF_FFFF, 32'd3, N + 1, 32'h5555_5555, 1'b0);
    run_op("divu /0", 2'b10, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 1'b0);
    run_op("remu /0", 2'b11, 32'd1234, 32'd0, 1, 32'd1234, 1'b0);
`else
    run_op("divu nodiv", 2'b10, 32'd100, 32'd7, 1, 32'd0, 1'b1);
    run_op("remu nodiv", 2'b11, 32'd100, 32'd0, 1, 32'd0, 1'b1);
`endif
    run_op("mul 6x7 again", 2'b00, 32'd6, 32'd7, N + 1, 32'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer shared by the execute stage for M-extension ops (MUL, MULHU, DIVU, REMU). It latches operands when the execute stage issues an M-op and steps a shift-add multiplier or restoring divider one bit per cycle. While busy it holds the pipeline via `stall`, which drives the stage `pipe_en` low. It returns a registered result for one cycle so the EX/MEM pipeline register captures it in place of the ALU output.

## Interface
- `N`, 32, operand/result width; counter width is `$clog2(N)+1`.

- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  execute stage presents an M-op this cycle
- `op`  in  2  00 MUL (low N), 01 MULHU (high N), 10 DIVU (quotient), 11 REMU (remainder); all unsigned
- `a`  in  N  operand A (rs1 after forwarding)
- `b`  in  N  operand B (rs2 after forwarding)
- `flush`  in  1  branch/jump taken (PC_sel); abort any op in flight
- `stall`  out  1  hold pipeline; execute stage uses `pipe_en = ~stall`
- `busy`  out  1  state is not IDLE
- `done`  out  1  `result` valid this cycle (one-cycle pulse)
- `err`  out  1  op not supported in this build; pulses with `done`
- `result`  out  N  registered op result

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `start & ~flush` latches `a`, `b`, `op`, clears the counter, and moves to BUSY.
  - Exception: DIVU/REMU with `b == 0` loads the result immediately and goes straight to DONE.
- BUSY, multiply:
  - 2N-bit product register; the low half is initialised to `a`.
  - Each cycle: if product[0], add `b` into the upper half (N+1-bit sum keeps the carry); then shift the product right by 1.
- BUSY, divide (restoring):
  - (N+1)-bit remainder and N-bit quotient shifter.
  - Each cycle: shift in the next dividend MSB; trial-subtract `b`; if non-negative, keep the difference and set the quotient bit to 1, else restore.
- Counter increments each BUSY cycle. After N iterations (count == N-1 at the edge), load `result` and go to DONE.
- Result selection:
  - MUL: product[N-1:0]; MULHU: product[2N-1:N].
  - DIVU: quotient; REMU: remainder[N-1:0].
  - Divide by zero: DIVU gives all ones; REMU gives `a`.
- DONE: `done=1` for one cycle, then IDLE. A `start` in the DONE cycle is ignored; the pipeline is advancing past this op.
- `start` while BUSY is ignored; the pipeline is stalled, so `start` stays high and is not re-sampled.
- `flush` in any state: the next edge goes to IDLE with no `done`; `result` keeps its old value.
- `flush` and `start` in the same IDLE cycle: flush wins and no op is launched.
- Reset values, held while `rst` is high:
  - state IDLE;
  - `result`, `done`, `err`, `busy`, counter and operand registers all 0;
  - `stall` forced 0.

## Timing
- `stall = (IDLE & start & ~flush) | BUSY`. It is combinational from `start`, so the pipeline freezes in the issue cycle T.
- For a normal op issued at cycle T:
  - BUSY spans T+1 … T+N; DONE is T+N+1.
  - `stall` is high for N+1 cycles (T … T+N) and low in DONE, so EX/MEM captures `result` at the end of T+N+1.
- Divide by zero issued at T: DONE at T+1; `stall` high for 1 cycle.
- `busy` is registered: high in BUSY and DONE, low in IDLE.
- `result`, `done`, `err` are registered and change only on clock edges.
- Async reset mid-operation aborts immediately. No `done` is produced after reset release.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath present; DIVU/REMU behave as above.
- `MULDIV_DIV_EN` undefined: no divider logic.
  - DIVU/REMU at `start` go IDLE→DONE in one cycle with `result = 0` and `err = 1`; `stall` is high only in the issue cycle.
  - MUL/MULHU are unchanged.
  - `err` is tied 0 when the macro is defined.

## Test plan
- MUL, a=6, b=7, N=32, `start` at T → `stall` high T…T+32; `done=1` and `result=42` at T+33; `busy` low at T+34.
- MULHU, a=b=0xFFFF_FFFF → `result=0xFFFF_FFFE` at T+33; MUL on the same operands → `0x0000_0001`.
- DIVU, a=100, b=7 → `result=14` at T+33; REMU → `2`. DIVU, b=0 → `done` at T+1 with `result=0xFFFF_FFFF`; REMU, b=0 → `result=a`.
- MUL start, `flush` at T+10 → IDLE at T+11, no `done`, `stall` low from T+11. `start` and `flush` together in IDLE → `stall=0`, state stays IDLE.
- Assert `rst` at T+5 of a DIVU → all outputs 0 immediately. After release, `start` with MUL a=3, b=5 → `result=15` after 33 cycles.
- Build without `MULDIV_DIV_EN`: DIVU start → `done=1`, `err=1`, `result=0` at T+1; MUL 6×7 still yields 42 with `err=0`.
